// File: rtl/sign_ext_pkg.sv
// rtl/sign_ext_pkg.sv - LEGv8 immediate format encodings and field positions
package sign_ext_pkg;

    // Ctrl format select encodings
    localparam logic [1:0] CTRL_I  = 2'b00;
    localparam logic [1:0] CTRL_D  = 2'b01;
    localparam logic [1:0] CTRL_B  = 2'b10;
    localparam logic [1:0] CTRL_CB = 2'b11;

    // Immediate field positions inside Imm26 (instruction bits [25:0])
    localparam int I_MSB  = 21;
    localparam int I_LSB  = 10;
    localparam int D_MSB  = 20;
    localparam int D_LSB  = 12;
    localparam int CB_MSB = 23;
    localparam int CB_LSB = 5;
    localparam int B_MSB  = 25;

    localparam int I_W  = I_MSB - I_LSB + 1;
    localparam int D_W  = D_MSB - D_LSB + 1;
    localparam int CB_W = CB_MSB - CB_LSB + 1;
    localparam int B_W  = B_MSB + 1;

endpackage

// File: rtl/sign_ext_core.sv
// rtl/sign_ext_core.sv - combinational Imm26/Ctrl to 64-bit immediate extender
//
// Ports:
//   Imm26  - instruction bits [25:0]
//   Ctrl   - format select (I, D, B, CB)
//   ext    - extended immediate (branch formats already shifted left by 2)
module sign_ext_core
    import sign_ext_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [25:0]       Imm26,
    input  logic [1:0]        Ctrl,
    output logic [DATA_W-1:0] ext
);

    always_comb begin
        ext = '0;
        unique case (Ctrl)
            CTRL_I:  ext = {{(DATA_W - I_W){1'b0}}, Imm26[I_MSB:I_LSB]};
            CTRL_D:  ext = {{(DATA_W - D_W){Imm26[D_MSB]}}, Imm26[D_MSB:D_LSB]};
            // Branch offsets are word offsets; the two appended zeros make them byte offsets
            CTRL_B:  ext = {{(DATA_W - B_W - 2){Imm26[B_MSB]}}, Imm26[B_MSB:0], 2'b00};
            CTRL_CB: ext = {{(DATA_W - CB_W - 2){Imm26[CB_MSB]}}, Imm26[CB_MSB:CB_LSB], 2'b00};
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/sign_extender.sv
// rtl/sign_extender.sv - registered LEGv8 immediate generator (1-cycle latency)
//
// Ports:
//   CLK      - system clock, rising edge
//   Reset_L  - synchronous active-low reset
//   Imm26    - instruction bits [25:0]
//   Ctrl     - format select: 00 I, 01 D, 10 B, 11 CB
//   InValid  - Imm26/Ctrl meaningful this cycle
//   BusImm   - registered extended immediate
//   OutValid - BusImm holds a result from a valid input
module sign_extender
    import sign_ext_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic [25:0]       Imm26,
    input  logic [1:0]        Ctrl,
    input  logic              InValid,
    output logic [DATA_W-1:0] BusImm,
    output logic              OutValid
);

    logic [DATA_W-1:0] ext;

    sign_ext_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .Imm26 (Imm26),
        .Ctrl  (Ctrl),
        .ext   (ext)
    );

    // BusImm only loads on a valid input so the last result stays visible while idle
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            BusImm   <= '0;
            OutValid <= 1'b0;
        end else begin
            OutValid <= InValid;
            if (InValid) begin
                BusImm <= ext;
            end
        end
    end

endmodule

// File: tb/tb_sign_extender.sv
// tb/tb_sign_extender.sv - directed self-checking bench for sign_extender
module tb_sign_extender;

    logic        CLK;
    logic        Reset_L;
    logic [25:0] Imm26;
    logic [1:0]  Ctrl;
    logic        InValid;
    logic [63:0] BusImm;
    logic        OutValid;

    int nchecks = 0;
    int nerrors = 0;

    sign_extender dut (
        .CLK      (CLK),
        .Reset_L  (Reset_L),
        .Imm26    (Imm26),
        .Ctrl     (Ctrl),
        .InValid  (InValid),
        .BusImm   (BusImm),
        .OutValid (OutValid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp)
        else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one input, take one rising edge, then sample 1 time unit later
    task automatic step(input logic rst_l, input logic vld, input logic [1:0] c, input logic [25:0] imm);
        Reset_L = rst_l;
        InValid = vld;
        Ctrl    = c;
        Imm26   = imm;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [63:0] bus, input logic vld);
        check({tag, ".bus"}, BusImm, bus);
        check({tag, ".vld"}, {63'd0, OutValid}, {63'd0, vld});
    endtask

    initial begin
        Reset_L = 1'b0;
        InValid = 1'b0;
        Ctrl    = 2'b00;
        Imm26   = '0;

        // Reset overrides a valid all-ones input
        step(1'b0, 1'b1, 2'b10, 26'h3FFFFFF);
        expect_out("rst0", 64'h0, 1'b0);
        step(1'b0, 1'b1, 2'b10, 26'h3FFFFFF);
        expect_out("rst1", 64'h0, 1'b0);

        // I-type
        step(1'b1, 1'b1, 2'b00, 26'hED1);
        expect_out("i_small", 64'h3, 1'b1);
        step(1'b1, 1'b1, 2'b00, 26'h3FFFC00);
        expect_out("i_ones", 64'hFFF, 1'b1);

        // D-type
        step(1'b1, 1'b1, 2'b01, 26'h103303);
        expect_out("d_neg", 64'hFFFFFFFFFFFFFF03, 1'b1);
        step(1'b1, 1'b1, 2'b01, 26'h0FF000);
        expect_out("d_pos", 64'hFF, 1'b1);

        // B-type
        step(1'b1, 1'b1, 2'b10, 26'h3FFCD5);
        expect_out("b_pos", 64'h0000000000FFF354, 1'b1);
        step(1'b1, 1'b1, 2'b10, 26'h2000000);
        expect_out("b_minneg", 64'hFFFFFFFFF8000000, 1'b1);
        step(1'b1, 1'b1, 2'b10, 26'h3FFFFFF);
        expect_out("b_ones", 64'hFFFFFFFFFFFFFFFC, 1'b1);

        // CB-type
        step(1'b1, 1'b1, 2'b11, 26'h3FFCD53);
        expect_out("cb_neg", 64'hFFFFFFFFFFFFF9A8, 1'b1);
        step(1'b1, 1'b1, 2'b11, 26'h00000E0);
        expect_out("cb_pos", 64'h1C, 1'b1);

        // Zero field with every bit outside the field set
        step(1'b1, 1'b1, 2'b00, 26'h3C003FF);
        expect_out("i_zero", 64'h0, 1'b1);
        step(1'b1, 1'b1, 2'b01, 26'h3E00FFF);
        expect_out("d_zero", 64'h0, 1'b1);
        step(1'b1, 1'b1, 2'b11, 26'h300001F);
        expect_out("cb_zero", 64'h0, 1'b1);
        step(1'b1, 1'b1, 2'b10, 26'h0);
        expect_out("b_zero", 64'h0, 1'b1);

        // Back-to-back alternating formats
        step(1'b1, 1'b1, 2'b11, 26'h3FFCD53);
        expect_out("bb0", 64'hFFFFFFFFFFFFF9A8, 1'b1);
        step(1'b1, 1'b1, 2'b00, 26'hED1);
        expect_out("bb1", 64'h3, 1'b1);
        step(1'b1, 1'b1, 2'b01, 26'h103303);
        expect_out("bb2", 64'hFFFFFFFFFFFFFF03, 1'b1);

        // Idle: OutValid drops, BusImm holds, inputs ignored
        step(1'b1, 1'b0, 2'b10, 26'h2000000);
        expect_out("hold0", 64'hFFFFFFFFFFFFFF03, 1'b0);
        step(1'b1, 1'b0, 2'b00, 26'h3FFFFFF);
        expect_out("hold1", 64'hFFFFFFFFFFFFFF03, 1'b0);

        // Resume after idle, then reset mid-stream
        step(1'b1, 1'b1, 2'b10, 26'h3FFCD5);
        expect_out("resume", 64'h0000000000FFF354, 1'b1);
        step(1'b0, 1'b1, 2'b01, 26'h103303);
        expect_out("rst_mid", 64'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
